shift_unit: RTL and testbench

SHIFT_UNIT -- requirements
Module: shift_unit

---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_step.sv | 24 ++
 rtl/shift_unit.sv | 100 ++++++++++
 tb/tb_shift_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op encoding and FSM state types for shift_unit
package shift_pkg;

  // Operation encoding as seen on in_op
  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASL = 2'b10,
    OP_ASR = 2'b11
  } shift_op_e;

  // Sequencer states: accept, iterate one bit per cycle, present result
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit shift for one op
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  shift_op_e        op_i,
  output logic [WIDTH-1:0] data_o
);

  // One-bit move; ASL is identical to LSL, ASR keeps the current sign bit
  always_comb begin
    data_o = {data_i[WIDTH-2:0], 1'b0};
    case (op_i)
      OP_LSL:  data_o = {data_i[WIDTH-2:0], 1'b0};
      OP_ASL:  data_o = {data_i[WIDTH-2:0], 1'b0};
      OP_LSR:  data_o = {1'b0, data_i[WIDTH-1:1]};
      OP_ASR:  data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
      default: data_o = {data_i[WIDTH-2:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - iterative shifter, one bit per cycle, valid/ready handshake
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Largest meaningful shift; only reachable as a clamp for non-power-of-2 WIDTH
  localparam int AMT_MAX_I = WIDTH - 1;
  localparam logic [AW:0] AMT_MAX = AMT_MAX_I[AW:0];

  shift_state_e     state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  shift_op_e        op_q, op_d;

  logic [WIDTH-1:0] step_data;
  logic [AW-1:0]    amt_sat;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data_i (work_q),
    .op_i   (op_q),
    .data_o (step_data)
  );

  // Clamp the requested amount so the counter never exceeds WIDTH-1
  always_comb begin
    amt_sat = in_amt;
    if ({1'b0, in_amt} > AMT_MAX) begin
      amt_sat = AMT_MAX[AW-1:0];
    end
  end

  // Next-state and datapath: latch in IDLE, shift while counter nonzero, hold in DONE
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = amt_sat;
          op_d    = shift_op_e'(in_op);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          work_d = step_data;
          cnt_d  = cnt_q - AW'(1);
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Returning to IDLE here means a request can only be taken next cycle
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OP_LSL;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = work_q;

endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - scoreboard bench for shift_unit (WIDTH=4 and WIDTH=6)
module tb_shift_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_data, out_data;
  logic [1:0] in_amt, in_op;

  // WIDTH=6 instance (exercises amount saturation)
  logic       in_valid6, in_ready6, out_valid6, out_ready6;
  logic [5:0] in_data6, out_data6;
  logic [2:0] in_amt6;
  logic [1:0] in_op6;

  shift_unit #(.WIDTH(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  shift_unit #(.WIDTH(6)) u_dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid6),
    .in_ready  (in_ready6),
    .in_data   (in_data6),
    .in_amt    (in_amt6),
    .in_op     (in_op6),
    .out_valid (out_valid6),
    .out_ready (out_ready6),
    .out_data  (out_data6)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;
  bit prev_valid = 1'b0;

  typedef struct {
    int data;
    int due;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: shift by the (clamped) amount in one arithmetic step
  function automatic int model(int w, int d, int a, int op);
    int mask;
    int sa;
    int hi;
    mask = (1 << w) - 1;
    sa = (a > w - 1) ? w - 1 : a;
    d = d & mask;
    hi = mask & ~(mask >> sa);
    case (op)
      0, 2:    return (d << sa) & mask;
      1:       return d >> sa;
      default: return (d >> sa) | ((((d >> (w - 1)) & 1) != 0) ? hi : 0);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Random backpressure when enabled
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compare each presented result against the scoreboard head
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          if (!prev_valid) begin
            chk("latency", 32'(cyc), 32'(exp_q[0].due));
            chk("out_data", 32'(out_data), 32'(exp_q[0].data));
          end else begin
            chk("out_data_stable", 32'(out_data), 32'(exp_q[0].data));
          end
          chk("in_ready_in_done", 32'(in_ready), 32'd0);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic send(input int d, input int a, input int op);
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_data  = d[3:0];
    in_amt   = a[1:0];
    in_op    = op[1:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back('{model(4, d, a, op), cyc + a + 1});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic run6(input int d, input int a, input int op);
    int ea;
    int n;
    int sa;
    sa = (a > 5) ? 5 : a;
    chk("w6_ready", 32'(in_ready6), 32'd1);
    in_valid6 = 1'b1;
    in_data6  = d[5:0];
    in_amt6   = a[2:0];
    in_op6    = op[1:0];
    @(posedge clk); #1;
    in_valid6 = 1'b0;
    ea = cyc;
    n = 0;
    while (!out_valid6 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid6) begin
      chk("w6_timeout", 32'd0, 32'd1);
    end else begin
      chk("w6_latency", 32'(cyc), 32'(ea + sa + 1));
      chk("w6_data", 32'(out_data6), 32'(model(6, d, a, op)));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    in_valid = 0; in_data = 0; in_amt = 0; in_op = 0; out_ready = 1;
    in_valid6 = 0; in_data6 = 0; in_amt6 = 0; in_op6 = 0; out_ready6 = 1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst6_in_ready", 32'(in_ready6), 32'd1);
    chk("rst6_out_valid", 32'(out_valid6), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors
    send(4'b0100, 1, 0);
    send(4'b1000, 1, 1);
    send(4'b1000, 1, 3);
    send(4'b0001, 1, 2);
    send(4'b1000, 3, 3);
    for (int op = 0; op < 4; op++) send(4'b0110, 0, op);
    send(4'b0111, 3, 3);
    send(4'b1011, 3, 0);
    drain();

    // Backpressure hold with ignored request pulses
    out_ready = 1'b0;
    send(4'b0101, 2, 1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      in_data  = 4'($urandom);
      in_amt   = 2'($urandom);
      in_op    = 2'($urandom);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("post_hold_in_ready", 32'(in_ready), 32'd1);

    // Reset mid-SHIFT aborts the operation
    send(4'b1010, 3, 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data", 32'(out_data), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(4'b1010, 3, 3);
    drain();

    // Saturation on the non-power-of-2 width
    run6(6'h2D, 7, 1);
    run6(6'h21, 6, 3);
    run6(6'h03, 7, 0);
    run6(6'h25, 5, 3);
    run6(6'h3F, 0, 2);
    run6(6'h16, 7, 2);

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
